// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, the NOP word, fetch FSM encoding and branch-offset helper.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_JAL   = 6'h03;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_BNE   = 6'h05;
    localparam logic [5:0]  OP_ADDI  = 6'h08;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_e;

    // Sign-extended word offset of a branch immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for a retiring instruction: jump beats taken branch beats sequential.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [25:0] i_instr_low,
    input  logic        i_jump,
    input  logic        i_beq,
    input  logic        i_bne,
    input  logic        i_zero,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_pc_plus4;
    logic        w_taken;

    // Sequential address and branch-taken decision.
    always_comb begin
        w_pc_plus4 = i_pc + 32'd4;
        w_taken    = (i_beq & i_zero) | (i_bne & ~i_zero);
    end

    // Priority select of the next PC.
    always_comb begin
        if (i_jump) begin
            o_next_pc = {w_pc_plus4[31:28], i_instr_low, 2'b00};
        end else if (w_taken) begin
            o_next_pc = w_pc_plus4 + branch_offset(i_instr_low[15:0]);
        end else begin
            o_next_pc = w_pc_plus4;
        end
    end

    assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction and advances on retire.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_imem_req,
    output logic [31:0]      o_imem_addr,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    output logic [31:0]      o_instr,
    output logic [5:0]       o_instrCode,
    output logic             o_instr_valid,
    input  logic             i_retire,
    input  logic             i_jump,
    input  logic             i_beq,
    input  logic             i_bne,
    input  logic             i_zero,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pc_plus4,
    output logic [CNT_W-1:0] o_retired_cnt
);

    fetch_state_e     r_state;
    logic             r_req;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_next_pc;
    logic [31:0]      w_pc_plus4;

    npc_calc u_npc_calc (
        .i_pc        (r_pc),
        .i_instr_low (r_instr[25:0]),
        .i_jump      (i_jump),
        .i_beq       (i_beq),
        .i_bne       (i_bne),
        .i_zero      (i_zero),
        .o_pc_plus4  (w_pc_plus4),
        .o_next_pc   (w_next_pc)
    );

    // Fetch FSM with PC, instruction, valid, request and retire-counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_FLUSH;
            r_req   <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                // One dead cycle swallows any acknowledge left over from before reset.
                ST_FLUSH: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (i_imem_ack) begin
                        r_instr <= i_imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_EXEC;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (i_retire) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_req   <= 1'b1;
                        r_state <= ST_FETCH;
                    end else begin
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_FLUSH;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_instr       = r_instr;
    assign o_instrCode   = r_instr[31:26];
    assign o_instr_valid = r_valid;
    assign o_retired_cnt = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch/retire sequences walk the PC across every 256MB region.
module tb_instr_fetch;

    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          o_imem_req;
    logic [31:0]   o_imem_addr;
    logic          i_imem_ack = 1'b0;
    logic [31:0]   i_imem_rdata = 32'h0;
    logic [31:0]   o_instr;
    logic [5:0]    o_instrCode;
    logic          o_instr_valid;
    logic          i_retire = 1'b0;
    logic          i_jump = 1'b0;
    logic          i_beq = 1'b0;
    logic          i_bne = 1'b0;
    logic          i_zero = 1'b0;
    logic [31:0]   o_pc;
    logic [31:0]   o_pc_plus4;
    logic [CW-1:0] o_retired_cnt;

    instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .o_instr(o_instr), .o_instrCode(o_instrCode), .o_instr_valid(o_instr_valid),
        .i_retire(i_retire), .i_jump(i_jump), .i_beq(i_beq), .i_bne(i_bne), .i_zero(i_zero),
        .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_retired_cnt(o_retired_cnt)
    );

    always #5 i_clk = ~i_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc  = 32'h0;
    int          exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: each new valid instruction is matched against the oldest expected fetch.
    logic prev_v = 1'b0;
    always @(negedge i_clk) begin
        logic [63:0] e;
        if (o_instr_valid === 1'b1 && prev_v !== 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", o_pc, e[63:32]);
                chk("sb_instr", o_instr, e[31:0]);
                chk("sb_opcode", {26'd0, o_instrCode}, {26'd0, e[31:26]});
                chk("sb_pc_plus4", o_pc_plus4, e[63:32] + 32'd4);
            end
        end
        prev_v = o_instr_valid;
    end

    // Wait for a request, hold off the ack for dly cycles (retire pulsed meanwhile), then deliver ins.
    task automatic fetch_only(input logic [31:0] ins, input int dly);
        int t = 0;
        while (o_imem_req !== 1'b1 && t < 20) begin
            @(posedge i_clk); #1; t++;
        end
        chk("req_high", {31'd0, o_imem_req}, 32'd1);
        chk("fetch_addr", o_imem_addr, exp_pc);
        for (int d = 0; d < dly; d++) begin
            i_retire = 1'b1;
            @(posedge i_clk); #1;
            i_retire = 1'b0;
            chk("wait_addr", o_imem_addr, exp_pc);
            chk("wait_req", {31'd0, o_imem_req}, 32'd1);
            chk("wait_valid", {31'd0, o_instr_valid}, 32'd0);
            chk("wait_cnt", {28'd0, o_retired_cnt}, exp_cnt[31:0] % 32'd16);
        end
        sb_q.push_back({exp_pc, ins});
        i_imem_ack = 1'b1;
        i_imem_rdata = ins;
        @(posedge i_clk); #1;
        i_imem_ack = 1'b0;
        i_imem_rdata = 32'hDEAD_BEEF;
        chk("exec_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("exec_req", {31'd0, o_imem_req}, 32'd0);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int dly, input logic j, input logic b,
                             input logic n, input logic z, input logic [31:0] nxt);
        fetch_only(ins, dly);
        i_retire = 1'b1; i_jump = j; i_beq = b; i_bne = n; i_zero = z;
        @(posedge i_clk); #1;
        i_retire = 1'b0; i_jump = 1'b0; i_beq = 1'b0; i_bne = 1'b0; i_zero = 1'b0;
        exp_pc = nxt;
        exp_cnt++;
        chk("next_pc", o_pc, exp_pc);
        chk("retired_cnt", {28'd0, o_retired_cnt}, exp_cnt[31:0] % 32'd16);
        chk("retire_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("retire_req", {31'd0, o_imem_req}, 32'd1);
    endtask

    // Reset with competing ack/retire; optionally present a stale ack during the FLUSH cycle.
    task automatic do_reset(input logic stale);
        i_rst_n = 1'b0; i_retire = 1'b1; i_imem_ack = 1'b1; i_imem_rdata = 32'h1234_5678;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_retire = 1'b0; i_imem_ack = stale; i_imem_rdata = 32'hFFFF_FFFF;
        exp_pc = 32'h0; exp_cnt = 0;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_cnt", {28'd0, o_retired_cnt}, 32'd0);
        @(posedge i_clk); #1;
        i_imem_ack = 1'b0;
        chk("flush_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("flush_instr", o_instr, 32'h0);
        chk("flush_req", {31'd0, o_imem_req}, 32'd1);
        chk("flush_addr", o_imem_addr, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Immediate ack at 0; j target 0x40 -> 0x100.
        do_reset(1'b0);
        run_instr(32'h0800_0040, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
        // beq imm -1: taken loops to itself, not taken falls through; same for bne.
        run_instr(32'h1022_FFFF, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        run_instr(32'h1022_FFFF, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104);
        run_instr(32'h1422_FFFF, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0104);
        run_instr(32'h1422_FFFF, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0108);
        // Climb to 0x4000_0000: jump to the top of each region, then step across.
        for (int k = 0; k < 4; k++) begin
            run_instr(32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 1'b0, {k[3:0], 28'hFFF_FFFC});
            run_instr(32'h2108_0001, k % 3, 1'b0, 1'b0, 1'b0, 1'b0, {k[3:0] + 4'd1, 28'h0});
        end
        run_instr(32'h1022_0003, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4000_0010);
        // Jump wins over a simultaneously taken beq.
        run_instr(32'h0800_0040, 0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4000_0100);
        // Continue to 0xFFFF_FFFC and wrap to 0; counter wraps along the way.
        for (int k = 4; k < 16; k++) begin
            run_instr(32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 1'b0, {k[3:0], 28'hFFF_FFFC});
            run_instr(32'h2108_0001, 0, 1'b0, 1'b0, 1'b0, 1'b0, {k[3:0] + 4'd1, 28'h0});
        end
        // Reset during EXEC, stale ack in the FLUSH cycle.
        fetch_only(32'h0000_0020, 0);
        do_reset(1'b1);
        // Delayed ack with retire pulses while fetching.
        run_instr(32'h2108_0002, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        // Reset mid-FETCH.
        @(posedge i_clk); #1;
        chk("midfetch_req", {31'd0, o_imem_req}, 32'd1);
        do_reset(1'b1);
        run_instr(32'h2108_0003, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        @(posedge i_clk); #1;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
